// File: rtl/fp_pkg.sv
// Shared floating-point emulator package: binary32 constants, rounding modes,
// unpacked-field bundle and the fp2int_seq FSM state encoding.
package fp_pkg;

    localparam logic [31:0] FP_NAN  = 32'h7FC0_0000;
    localparam logic [31:0] FP_INF  = 32'h7F80_0000;
    localparam logic [31:0] FP_MINF = 32'hFF80_0000;
    localparam int          FP_BIAS = 127;

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    // -2^31 is the one binary32 value with E = 31 that fits an int32
    localparam logic [31:0] FP_INT_MIN = 32'hCF00_0000;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RDN = 2'b10,
        RM_RUP = 2'b11
    } rmode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIFY,
        S_SHIFT,
        S_ROUND,
        S_DONE
    } f2i_state_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
        logic        is_nan;
        logic        is_inf;
        logic        is_zero;
        logic        is_denorm;
    } fp32_fields_t;

endpackage

// File: rtl/fp32_unpack.sv
// Combinational binary32 field splitter and classifier.
// Ports: data (binary32 in), fields (sign/exp/frac plus class bits out).
module fp32_unpack
    import fp_pkg::*;
(
    input  logic [31:0]  data,
    output fp32_fields_t fields
);

    logic exp_max;
    logic exp_min;
    logic frac_nz;

    assign exp_max = (data[30:23] == 8'hFF);
    assign exp_min = (data[30:23] == 8'h00);
    assign frac_nz = (data[22:0] != 23'd0);

    assign fields.sign      = data[31];
    assign fields.exp       = data[30:23];
    assign fields.frac      = data[22:0];
    assign fields.is_nan    = exp_max & frac_nz;
    assign fields.is_inf    = exp_max & ~frac_nz;
    assign fields.is_zero   = exp_min & ~frac_nz;
    assign fields.is_denorm = exp_min & frac_nz;

endmodule

// File: rtl/fp2int_seq.sv
// Multi-cycle binary32 -> int32 converter, one alignment bit per cycle.
// Ports: clk, rst_n, in_valid/in_ready/in_data/in_rmode operand handshake,
// out_valid/out_ready/out_data/out_invalid/out_inexact result handshake.
module fp2int_seq
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_rmode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_invalid,
    output logic        out_inexact
);

    f2i_state_t   state_q;
    f2i_state_t   state_d;
    fp32_fields_t fld;

    logic [31:0] op_q;
    rmode_t      rm_q;
    logic        sign_q;
    logic [31:0] mag_q;
    logic        g_q;
    logic        st_q;
    logic [4:0]  cnt_q;
    logic        left_q;
    logic        spec_q;
    logic        inv_q;

    logic        cls_spec;
    logic        cls_inv;
    logic        cls_left;
    logic [4:0]  cls_n;
    logic [31:0] cls_val;
    logic [31:0] cls_mag;
    logic        inc;
    logic [31:0] sum;

    fp32_unpack u_unpack (
        .data   (op_q),
        .fields (fld)
    );

    assign in_ready = (state_q == S_IDLE);

    // exp >= 158 means E >= 31, exp >= 150 means E >= 23;
    // right shift 150 - exp saturates at 25 for exp <= 125 and denormals.
    always_comb begin
        cls_spec = 1'b0;
        cls_inv  = 1'b0;
        cls_left = 1'b0;
        cls_n    = 5'd0;
        cls_val  = 32'd0;
        cls_mag  = {8'd0, (fld.exp != 8'd0), fld.frac};
        unique case (1'b1)
            fld.is_nan: begin
                cls_spec = 1'b1;
                cls_inv  = 1'b1;
                cls_val  = INT_MAX;
            end
            (fld.exp >= 8'd158) && (op_q != FP_INT_MIN) && !fld.is_nan: begin
                cls_spec = 1'b1;
                cls_inv  = 1'b1;
                cls_val  = fld.sign ? INT_MIN : INT_MAX;
            end
            (op_q == FP_INT_MIN): begin
                cls_spec = 1'b1;
                cls_val  = INT_MIN;
            end
            fld.is_zero: begin
                cls_spec = 1'b1;
            end
            (fld.exp >= 8'd150) && (fld.exp < 8'd158): begin
                cls_left = 1'b1;
                cls_n    = 5'(fld.exp - 8'd150);
            end
            default: begin
                cls_n = (fld.exp <= 8'd125) ? 5'd25
                                            : 5'(8'd150 - fld.exp);
            end
        endcase
    end

    always_comb begin
        inc = 1'b0;
        unique case (rm_q)
            RM_RNE: inc = g_q & (st_q | mag_q[0]);
            RM_RTZ: inc = 1'b0;
            RM_RDN: inc = sign_q & (g_q | st_q);
            RM_RUP: inc = ~sign_q & (g_q | st_q);
            default: inc = 1'b0;
        endcase
    end

    assign sum = mag_q + {31'd0, inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) state_d = S_CLASSIFY;
            end
            S_CLASSIFY: begin
                if (cls_spec || cls_n == 5'd0) state_d = S_ROUND;
                else                           state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == 5'd1) state_d = S_ROUND;
            end
            S_ROUND: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_valid && out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= 32'd0;
            rm_q        <= RM_RNE;
            sign_q      <= 1'b0;
            mag_q       <= 32'd0;
            g_q         <= 1'b0;
            st_q        <= 1'b0;
            cnt_q       <= 5'd0;
            left_q      <= 1'b0;
            spec_q      <= 1'b0;
            inv_q       <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= 32'd0;
            out_invalid <= 1'b0;
            out_inexact <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q <= in_data;
                        rm_q <= rmode_t'(in_rmode);
                    end
                end
                S_CLASSIFY: begin
                    sign_q <= fld.sign;
                    mag_q  <= cls_spec ? cls_val : cls_mag;
                    g_q    <= 1'b0;
                    st_q   <= 1'b0;
                    cnt_q  <= cls_n;
                    left_q <= cls_left;
                    spec_q <= cls_spec;
                    inv_q  <= cls_inv;
                end
                S_SHIFT: begin
                    cnt_q <= cnt_q - 5'd1;
                    if (left_q) begin
                        mag_q <= mag_q << 1;
                    end else begin
                        mag_q <= mag_q >> 1;
                        g_q   <= mag_q[0];
                        st_q  <= st_q | g_q;
                    end
                end
                S_ROUND: begin
                    if (spec_q) begin
                        out_data    <= mag_q;
                        out_invalid <= inv_q;
                        out_inexact <= 1'b0;
                    end else begin
                        out_data    <= sign_q ? (32'd0 - sum) : sum;
                        out_invalid <= 1'b0;
                        out_inexact <= g_q | st_q;
                    end
                end
                S_DONE: begin
                    // out_valid rises one cycle into DONE and drops on transfer
                    if (!out_valid)     out_valid <= 1'b1;
                    else if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp2int_seq.sv
// Self-checking bench for fp2int_seq: directed cases, random operands against
// an exact-arithmetic reference, back-pressure and mid-operation reset.
module tb_fp2int_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_rmode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_invalid;
    logic        out_inexact;

    int errs = 0;
    int checks = 0;

    fp2int_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_rmode    (in_rmode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_invalid (out_invalid),
        .out_inexact (out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact value = m * 2^(E-23); integer part and remainder vs. one half
    // decide the rounding.
    task automatic ref_model(input logic [31:0] x, input logic [1:0] rm,
                             output logic [31:0] r, output logic inv,
                             output logic inx, output int n);
        logic        s;
        int          e;
        int          ee;
        int          sh;
        longint      m;
        longint      ip;
        longint      rem;
        longint      half;
        logic        gt;
        logic        tie;
        logic        nz;
        logic        up;
        longint      mag;
        s = x[31];
        e = int'(x[30:23]);
        inv = 1'b0;
        inx = 1'b0;
        n = 0;
        r = 32'd0;
        if (e == 255 && x[22:0] != 0) begin
            r = 32'h7FFF_FFFF;
            inv = 1'b1;
        end else if (e == 255) begin
            r = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            inv = 1'b1;
        end else if (e == 0 && x[22:0] == 0) begin
            r = 32'd0;
        end else begin
            if (e == 0) begin
                m = longint'(x[22:0]);
                ee = -126;
            end else begin
                m = longint'(x[22:0]) + (64'd1 << 23);
                ee = e - 127;
            end
            if (ee >= 31) begin
                if (x == 32'hCF00_0000) begin
                    r = 32'h8000_0000;
                end else begin
                    r = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    inv = 1'b1;
                end
            end else begin
                if (e == 0)        n = 25;
                else if (ee >= 23) n = ee - 23;
                else               n = (23 - ee > 25) ? 25 : 23 - ee;
                sh = 23 - ee;
                if (sh <= 0) begin
                    ip = m << (-sh);
                    gt = 1'b0; tie = 1'b0; nz = 1'b0;
                end else if (sh >= 40) begin
                    ip = 0;
                    gt = 1'b0; tie = 1'b0; nz = 1'b1;
                end else begin
                    ip = m >> sh;
                    rem = m - (ip << sh);
                    half = 64'd1 << (sh - 1);
                    gt = rem > half;
                    tie = rem == half;
                    nz = rem != 0;
                end
                case (rm)
                    2'd0: up = gt || (tie && ip[0]);
                    2'd1: up = 1'b0;
                    2'd2: up = s && nz;
                    default: up = !s && nz;
                endcase
                mag = ip + longint'(up);
                r = s ? 32'(-mag) : 32'(mag);
                inx = nz;
            end
        end
    endtask

    // Starts an operation and waits (bounded) for the result; leaves the
    // result unconsumed when out_ready is low.
    task automatic start_wait(input logic [31:0] x, input logic [1:0] rm,
                              output int lat, output logic got);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = x;
        in_rmode = rm;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_rmode = 2'($urandom);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) got = 1'b1;
        end
    endtask

    task automatic run_op(input logic [31:0] x, input logic [1:0] rm,
                          input logic [31:0] er, input logic ei,
                          input logic ex, input int n);
        int   lat;
        logic got;
        start_wait(x, rm, lat, got);
        chk("out_valid_seen", 32'(got), 32'd1);
        chk("latency", 32'(lat), 32'(n + 3));
        chk("data", out_data, er);
        chk("invalid", 32'(out_invalid), 32'(ei));
        chk("inexact", 32'(out_inexact), 32'(ex));
        @(posedge clk);
        #1;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("ready_back", 32'(in_ready), 32'd1);
    endtask

    typedef struct {
        logic [31:0] x;
        logic [1:0]  rm;
        logic [31:0] r;
        logic        inv;
        logic        inx;
    } vec_t;

    vec_t dir[$];

    initial begin
        logic [31:0] r;
        logic        inv;
        logic        inx;
        int          n;
        int          lat;
        logic        got;
        logic [31:0] x;
        logic [31:0] held;
        logic        seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_rmode  = 2'd0;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_flags", {30'd0, out_invalid, out_inexact}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        dir.push_back('{32'h3F80_0000, 2'd0, 32'h0000_0001, 1'b0, 1'b0});
        dir.push_back('{32'h4020_0000, 2'd0, 32'h0000_0002, 1'b0, 1'b1});
        dir.push_back('{32'h4020_0000, 2'd3, 32'h0000_0003, 1'b0, 1'b1});
        dir.push_back('{32'h4020_0000, 2'd1, 32'h0000_0002, 1'b0, 1'b1});
        dir.push_back('{32'hBFC0_0000, 2'd0, 32'hFFFF_FFFE, 1'b0, 1'b1});
        dir.push_back('{32'hBFC0_0000, 2'd1, 32'hFFFF_FFFF, 1'b0, 1'b1});
        dir.push_back('{32'hBFC0_0000, 2'd2, 32'hFFFF_FFFE, 1'b0, 1'b1});
        dir.push_back('{32'h4F00_0000, 2'd0, 32'h7FFF_FFFF, 1'b1, 1'b0});
        dir.push_back('{32'hCF00_0000, 2'd0, 32'h8000_0000, 1'b0, 1'b0});
        dir.push_back('{32'h7FC0_0000, 2'd0, 32'h7FFF_FFFF, 1'b1, 1'b0});
        dir.push_back('{32'hFF80_0000, 2'd0, 32'h8000_0000, 1'b1, 1'b0});
        dir.push_back('{32'h0000_0001, 2'd3, 32'h0000_0001, 1'b0, 1'b1});
        dir.push_back('{32'h0000_0000, 2'd2, 32'h0000_0000, 1'b0, 1'b0});
        dir.push_back('{32'h4EFF_FFFF, 2'd0, 32'h7FFF_FF80, 1'b0, 1'b0});

        foreach (dir[i]) begin
            ref_model(dir[i].x, dir[i].rm, r, inv, inx, n);
            run_op(dir[i].x, dir[i].rm, dir[i].r, dir[i].inv, dir[i].inx, n);
        end

        for (int i = 0; i < 80; i++) begin
            x = $urandom;
            if (i % 2 == 0) x[30:23] = 8'($urandom_range(100, 160));
            in_rmode = 2'($urandom_range(0, 3));
            ref_model(x, in_rmode, r, inv, inx, n);
            run_op(x, in_rmode, r, inv, inx, n);
        end

        out_ready = 1'b0;
        start_wait(32'h4020_0000, 2'd3, lat, got);
        chk("bp_valid_seen", 32'(got), 32'd1);
        held = out_data;
        chk("bp_data", held, 32'h0000_0003);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'h3F80_0000;
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data", out_data, 32'h0000_0003);
            chk("bp_hold_inx", 32'(out_inexact), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);

        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        in_rmode = 2'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_data", out_data, 32'd0);
        chk("arst_flags", {30'd0, out_invalid, out_inexact}, 32'd0);
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("arst_no_output", 32'(seen), 32'd0);
        run_op(32'h3F80_0000, 2'd0, 32'h0000_0001, 1'b0, 1'b0, 23);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
